// File: rtl/axi_lite_selftest_master.sv
// axi_lite_selftest_master
// Bring-up self-test master for the control-bus register bank. On start it
// writes seed + i*PATTERN_STEP to NUM_REGS consecutive registers, reads each
// one back immediately after its write, and reports pass / error class /
// first failing index. It stops at the first failure.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; done/pass/err_* hold the last result
// S_WR    | AWVALID/WVALID raised, each dropped on its own handshake
// S_WRESP | BREADY raised, waiting for BVALID, BRESP checked on arrival
// S_RD    | ARVALID raised at the same address, waiting for ARREADY
// S_RDATA | RREADY raised; RDATA/RRESP captured, then checked a cycle later
// S_NEXT  | advance index/address/pattern or finish with pass
// S_FAIL  | record fail_index, clear pass
// S_DONE  | done set, busy cleared; returns to S_IDLE next cycle
module axi_lite_selftest_master #(
  parameter int unsigned                    C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                    C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  BASE_ADDR          = '0,
  parameter int unsigned                    NUM_REGS           = 4,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]  PATTERN_STEP       = 32'h1111_1111,
  parameter int unsigned                    TIMEOUT_CYCLES     = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     pattern_seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              err_resp,
  output logic                              err_mismatch,
  output logic                              err_timeout,
  output logic [7:0]                        fail_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_NEXT, S_FAIL, S_DONE
  } state_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_M_AXI_ADDR_WIDTH'(4);

  state_t                          state;
  logic [7:0]                      index;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   exp_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data_q;
  logic [1:0]                      rd_resp_q;
  logic                            rd_got;
  logic                            aw_done;
  logic                            w_done;
  logic [TW-1:0]                   tmo_cnt;
  logic                            arm_q;
  logic                            aw_fin;
  logic                            w_fin;
  logic                            timed;
  logic                            tmo_hit;

  // Address and pattern come straight from registers; both read and write
  // target the same register, so one address register feeds both channels.
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = exp_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  // Write phase completion: earlier handshake or one happening this cycle.
  assign aw_fin  = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_fin   = w_done  | (M_AXI_WVALID  & M_AXI_WREADY);
  assign timed   = (state == S_WR) || (state == S_WRESP) ||
                   (state == S_RD) || (state == S_RDATA);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Sequencer: every state change zeroes the phase timer; handshakes take
  // priority over a timeout that expires in the same cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= S_IDLE;
      index         <= '0;
      addr_q        <= '0;
      exp_q         <= '0;
      rd_data_q     <= '0;
      rd_resp_q     <= '0;
      rd_got        <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      tmo_cnt       <= '0;
      arm_q         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_resp      <= 1'b0;
      err_mismatch  <= 1'b0;
      err_timeout   <= 1'b0;
      fail_index    <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      // arm_q masks a start that coincides with the first edge after reset
      arm_q   <= 1'b1;
      tmo_cnt <= timed ? tmo_cnt + TW'(1) : '0;
      case (state)
        S_IDLE: begin
          if (start && arm_q) begin
            state         <= S_WR;
            index         <= '0;
            addr_q        <= BASE_ADDR;
            exp_q         <= pattern_seed;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rd_got        <= 1'b0;
            tmo_cnt       <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_resp      <= 1'b0;
            err_mismatch  <= 1'b0;
            err_timeout   <= 1'b0;
            fail_index    <= '0;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
          end
        end
        S_WR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (M_AXI_WVALID && M_AXI_WREADY) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state        <= S_WRESP;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            tmo_cnt      <= '0;
            M_AXI_BREADY <= 1'b1;
          end else if (tmo_hit) begin
            state         <= S_FAIL;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            tmo_cnt       <= '0;
            err_timeout   <= 1'b1;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
          end
        end
        S_WRESP: begin
          if (M_AXI_BREADY && M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            tmo_cnt      <= '0;
            if (M_AXI_BRESP != 2'b00) begin
              err_resp <= 1'b1;
              state    <= S_FAIL;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= S_RD;
            end
          end else if (tmo_hit) begin
            M_AXI_BREADY <= 1'b0;
            tmo_cnt      <= '0;
            err_timeout  <= 1'b1;
            state        <= S_FAIL;
          end
        end
        S_RD: begin
          if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            tmo_cnt       <= '0;
            state         <= S_RDATA;
          end else if (tmo_hit) begin
            M_AXI_ARVALID <= 1'b0;
            tmo_cnt       <= '0;
            err_timeout   <= 1'b1;
            state         <= S_FAIL;
          end
        end
        S_RDATA: begin
          // Compare is done on the captured copy to keep the slave's RDATA
          // off the 32-bit compare path.
          if (rd_got) begin
            rd_got  <= 1'b0;
            tmo_cnt <= '0;
            if (rd_resp_q != 2'b00) begin
              err_resp <= 1'b1;
              state    <= S_FAIL;
            end else if (rd_data_q != exp_q) begin
              err_mismatch <= 1'b1;
              state        <= S_FAIL;
            end else begin
              state <= S_NEXT;
            end
          end else if (M_AXI_RREADY && M_AXI_RVALID) begin
            rd_data_q    <= M_AXI_RDATA;
            rd_resp_q    <= M_AXI_RRESP;
            rd_got       <= 1'b1;
            M_AXI_RREADY <= 1'b0;
          end else if (tmo_hit) begin
            M_AXI_RREADY <= 1'b0;
            tmo_cnt      <= '0;
            err_timeout  <= 1'b1;
            state        <= S_FAIL;
          end
        end
        S_NEXT: begin
          if (index == LAST_IDX) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            index         <= index + 8'd1;
            addr_q        <= addr_q + ADDR_STEP;
            exp_q         <= exp_q + PATTERN_STEP;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= S_WR;
          end
        end
        S_FAIL: begin
          fail_index <= index;
          pass       <= 1'b0;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// tb_axi_lite_selftest_master
// Directed bench with a small 4-register AXI4-Lite slave whose ready delays,
// response errors, readback corruption and AR stall can be configured.
module tb_axi_lite_selftest_master;

  logic        tb_ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [31:0] pattern_seed;
  logic        busy, done, pass, err_resp, err_mismatch, err_timeout;
  logic [7:0]  fail_index;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int n_checks = 0;
  int n_errors = 0;

  // slave configuration (written by the stimulus only)
  int aw_delay, w_delay, bad_b_idx, bad_r_idx;
  bit ar_never;

  // slave state (written by the slave process only)
  logic [31:0] mem [4];
  int          wr_cnt [4];
  int          ar_cnt [4];
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s, ar_addr_s, aw_addr_l, w_data_l;
  int          aw_cnt, w_cnt;

  // monitor counters
  int aw_only_cyc = 0;
  int w_only_cyc  = 0;
  int arv_cyc     = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_selftest_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(tb_ACLK), .ARESET(ARESET), .start(start), .pattern_seed(pattern_seed),
    .busy(busy), .done(done), .pass(pass), .err_resp(err_resp),
    .err_mismatch(err_mismatch), .err_timeout(err_timeout), .fail_index(fail_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Slave: sample handshakes at the rising edge, update drives at the falling edge.
  always begin
    int idx;
    @(posedge tb_ACLK);
    aw_hs     = M_AXI_AWVALID && M_AXI_AWREADY;
    w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    b_hs      = M_AXI_BVALID && M_AXI_BREADY;
    ar_hs     = M_AXI_ARVALID && M_AXI_ARREADY;
    r_hs      = M_AXI_RVALID && M_AXI_RREADY;
    aw_addr_s = M_AXI_AWADDR;
    w_data_s  = M_AXI_WDATA;
    ar_addr_s = M_AXI_ARADDR;
    @(negedge tb_ACLK);
    if (ARESET) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
      M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
      aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (b_hs) begin
        M_AXI_BVALID = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      end
      if (aw_hs) begin
        M_AXI_AWREADY = 1'b0; aw_got = 1'b1; aw_addr_l = aw_addr_s; aw_cnt = 0;
      end
      if (w_hs) begin
        M_AXI_WREADY = 1'b0; w_got = 1'b1; w_data_l = w_data_s; w_cnt = 0;
      end
      if (aw_got && w_got && !M_AXI_BVALID) begin
        idx = int'(aw_addr_l[3:2]);
        wr_cnt[idx] = wr_cnt[idx] + 1;
        if (idx == bad_b_idx) M_AXI_BRESP = 2'b10;
        else begin
          M_AXI_BRESP = 2'b00;
          mem[idx] = w_data_l;
        end
        M_AXI_BVALID = 1'b1;
      end
      if (r_hs) M_AXI_RVALID = 1'b0;
      if (ar_hs) begin
        M_AXI_ARREADY = 1'b0;
        idx = int'(ar_addr_s[3:2]);
        ar_cnt[idx] = ar_cnt[idx] + 1;
        M_AXI_RDATA = mem[idx];
        if (idx == bad_r_idx) M_AXI_RDATA[0] = 1'b0;
        M_AXI_RRESP = 2'b00;
        M_AXI_RVALID = 1'b1;
      end
      if (M_AXI_AWVALID && !aw_got && !M_AXI_AWREADY) begin
        if (aw_cnt >= aw_delay) M_AXI_AWREADY = 1'b1;
        else aw_cnt = aw_cnt + 1;
      end
      if (M_AXI_WVALID && !w_got && !M_AXI_WREADY) begin
        if (w_cnt >= w_delay) M_AXI_WREADY = 1'b1;
        else w_cnt = w_cnt + 1;
      end
      if (M_AXI_ARVALID && !M_AXI_ARREADY && !M_AXI_RVALID && !ar_never)
        M_AXI_ARREADY = 1'b1;
    end
  end

  // Monitor: cycles with only one write VALID up, and cycles with ARVALID up.
  always @(negedge tb_ACLK) begin
    if (M_AXI_AWVALID && !M_AXI_WVALID) aw_only_cyc <= aw_only_cyc + 1;
    if (M_AXI_WVALID && !M_AXI_AWVALID) w_only_cyc <= w_only_cyc + 1;
    if (M_AXI_ARVALID) arv_cyc <= arv_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start with seed, optionally re-pulse start at cycle inject_at,
  // then wait (bounded) for done. cyc = falling edges from acceptance to done.
  task automatic run_test(input string tag, input logic [31:0] seed,
                          input int inject_at, output int cyc);
    @(negedge tb_ACLK);
    start = 1'b1; pattern_seed = seed;
    @(negedge tb_ACLK);
    start = 1'b0; pattern_seed = 32'hFFFF_0000;
    chk({tag, "_valid_after_start"}, 32'({busy, M_AXI_AWVALID, M_AXI_WVALID}), 32'h7);
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge tb_ACLK);
      cyc++;
      start = (cyc == inject_at);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'h1);
  endtask

  initial begin
    int cyc, snap_a, snap_b;
    ARESET = 1'b1; start = 1'b0; pattern_seed = '0;
    aw_delay = 0; w_delay = 0; bad_b_idx = -1; bad_r_idx = -1; ar_never = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem[i] = '0; wr_cnt[i] = 0; ar_cnt[i] = 0;
    end
    repeat (3) @(negedge tb_ACLK);
    chk("reset_status", 32'({busy, done, pass, err_resp, err_mismatch, err_timeout, fail_index}), 32'h0);
    chk("reset_axi", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'h0);
    chk("reset_addr_data", M_AXI_AWADDR | M_AXI_WDATA, 32'h0);
    ARESET = 1'b0;
    repeat (2) @(negedge tb_ACLK);

    // zero-wait slave, nominal pattern
    run_test("t1", 32'h0101_FFFF, 0, cyc);
    chk("t1_cycles", 32'(cyc), 32'd24);
    chk("t1_pass", 32'(pass), 32'h1);
    chk("t1_errs", 32'({err_resp, err_mismatch, err_timeout}), 32'h0);
    chk("t1_mem0", mem[0], 32'h0101_FFFF);
    chk("t1_mem1", mem[1], 32'h1213_1110);
    chk("t1_mem2", mem[2], 32'h2324_2221);
    chk("t1_mem3", mem[3], 32'h3435_3332);
    chk("t1_prot_strb", 32'({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}), 32'h00F);
    repeat (2) @(negedge tb_ACLK);
    chk("t1_done_held_idle", 32'({done, busy}), 32'h2);

    // AWREADY delayed, start pulsed while busy must be ignored
    aw_delay = 3;
    snap_a = aw_only_cyc;
    run_test("t2a", 32'hA5A5_0000, 5, cyc);
    chk("t2a_pass", 32'(pass), 32'h1);
    chk("t2a_mem3", mem[3], 32'hD8D8_3333);
    chk("t2a_aw_held_w_dropped", 32'(aw_only_cyc > snap_a), 32'h1);
    aw_delay = 0; w_delay = 3;
    snap_b = w_only_cyc;
    run_test("t2b", 32'h5A5A_5A5A, 0, cyc);
    chk("t2b_pass", 32'(pass), 32'h1);
    chk("t2b_mem3", mem[3], 32'h8D8D_8D8D);
    chk("t2b_w_held_aw_dropped", 32'(w_only_cyc > snap_b), 32'h1);
    w_delay = 0;

    // BRESP SLVERR on register 1
    bad_b_idx = 1;
    snap_a = ar_cnt[1];
    run_test("t3", 32'h0101_FFFF, 0, cyc);
    chk("t3_errs", 32'({err_resp, err_mismatch, err_timeout}), 32'h4);
    chk("t3_fail_index", 32'(fail_index), 32'd1);
    chk("t3_pass", 32'(pass), 32'h0);
    chk("t3_no_ar_reg1", 32'(ar_cnt[1] - snap_a), 32'd0);
    bad_b_idx = -1;

    // readback of register 2 has bit 0 forced low
    bad_r_idx = 2;
    snap_a = wr_cnt[3]; snap_b = ar_cnt[3];
    run_test("t4", 32'h0101_FFFF, 0, cyc);
    chk("t4_errs", 32'({err_resp, err_mismatch, err_timeout}), 32'h2);
    chk("t4_fail_index", 32'(fail_index), 32'd2);
    chk("t4_pass", 32'(pass), 32'h0);
    chk("t4_no_traffic_reg3", 32'((wr_cnt[3] - snap_a) + (ar_cnt[3] - snap_b)), 32'd0);
    bad_r_idx = -1;

    // ARREADY never asserted: 16 cycles in RD then FAIL, DONE
    ar_never = 1'b1;
    snap_a = arv_cyc;
    run_test("t5", 32'h0101_FFFF, 0, cyc);
    chk("t5_errs", 32'({err_resp, err_mismatch, err_timeout}), 32'h1);
    chk("t5_fail_index", 32'(fail_index), 32'd0);
    chk("t5_arvalid_low", 32'({pass, M_AXI_ARVALID}), 32'h0);
    chk("t5_rd_cycles", 32'(arv_cyc - snap_a), 32'd16);
    chk("t5_cycles", 32'(cyc), 32'd19);
    ar_never = 1'b0;

    // reset pulsed while waiting in WRESP
    @(negedge tb_ACLK);
    start = 1'b1; pattern_seed = 32'h1234_5678;
    @(negedge tb_ACLK);
    start = 1'b0;
    cyc = 0;
    while (!M_AXI_BREADY && cyc < 20) begin
      @(negedge tb_ACLK);
      cyc++;
    end
    chk("t6_reached_wresp", 32'(M_AXI_BREADY), 32'h1);
    #2 ARESET = 1'b1;
    #1;
    chk("t6_async_status", 32'({busy, done, pass, err_resp, err_mismatch, err_timeout, fail_index}), 32'h0);
    chk("t6_async_axi", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 32'h0);
    chk("t6_async_addr", M_AXI_AWADDR, 32'h0);
    repeat (2) @(negedge tb_ACLK);
    ARESET = 1'b0; start = 1'b1; pattern_seed = 32'h0BAD_0BAD;
    @(negedge tb_ACLK);
    start = 1'b0;
    chk("t6_start_at_release_ignored", 32'({busy, M_AXI_AWVALID}), 32'h0);
    repeat (2) @(negedge tb_ACLK);
    run_test("t6", 32'hDEAD_0011, 0, cyc);
    chk("t6_cycles", 32'(cyc), 32'd24);
    chk("t6_pass_errs", 32'({pass, err_resp, err_mismatch, err_timeout}), 32'h8);
    chk("t6_mem2_wrap", mem[2], 32'h00CF_2233);
    chk("t6_mem3_wrap", mem[3], 32'h11E0_3344);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
